// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes, ALU operations and data path select values.
package mc_ctrl_pkg;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_en;
        logic       done;
    } ctrl_t;

    function automatic logic funct_supported(input logic [5:0] f);
        return (f == FUNCT_ADD) || (f == FUNCT_SUB) || (f == FUNCT_AND) ||
               (f == FUNCT_OR)  || (f == FUNCT_SLT);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp and the R-type funct field to the 3-bit ALU operation code.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] Funct,
    input  logic [1:0] ALUOp,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unknown funct codes fall back to add; the FSM treats them as NOPs
                case (Funct)
                    FUNCT_ADD: ALUControl = ALU_ADD;
                    FUNCT_SUB: ALUControl = ALU_SUB;
                    FUNCT_AND: ALUControl = ALU_AND;
                    FUNCT_OR:  ALUControl = ALU_OR;
                    FUNCT_SLT: ALUControl = ALU_SLT;
                    default:   ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS data path, with a retire pulse
// and a retired-instruction counter for bring-up.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int CountWidth = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            Op,
    input  logic [5:0]            Funct,
    input  logic                  Zero,
    output logic                  PCWrite,
    output logic [1:0]            PCSrc,
    output logic                  RegWrite,
    output logic                  IorD,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  RegDst,
    output logic                  MemtoReg,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [2:0]            ALUControl,
    output logic [3:0]            state_o,
    output logic                  instr_done,
    output logic [CountWidth-1:0] instr_count
);

    logic [3:0]            state_q, state_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  load_q, load_d;
    logic [1:0]            alu_op;
    logic [2:0]            alu_ctl;
    ctrl_t                 ctrl, ctrl_out;

    alu_decoder u_alu_decoder (
        .Funct      (Funct),
        .ALUOp      (alu_op),
        .ALUControl (alu_ctl)
    );

    // Op is only looked at in DECODE, so the lw/sw choice is remembered here
    // for the MEMADR transition.
    always_comb begin
        ctrl    = '0;
        alu_op  = ALUOP_ADD;
        state_d = S_FETCH;
        load_d  = load_q;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_en    = 1'b1;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
                state_d        = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_en    = 1'b1;
                load_d         = (Op == OP_LW);
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        ctrl.done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_en    = 1'b1;
                state_d        = load_q ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
                state_d   = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.done       = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_en    = 1'b1;
                if (funct_supported(Funct)) begin
                    alu_op  = ALUOP_FUNCT;
                    state_d = S_ALUWB;
                end else begin
                    ctrl.done = 1'b1;
                end
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_en    = 1'b1;
                alu_op         = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.pc_write  = Zero;
                ctrl.done      = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_en    = 1'b1;
                state_d        = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
                ctrl.done     = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset squashes every output combinationally so no write can slip out
    // in the cycle reset is asserted.
    assign ctrl_out = reset ? '0 : ctrl;

    assign PCWrite    = ctrl_out.pc_write;
    assign PCSrc      = ctrl_out.pc_src;
    assign RegWrite   = ctrl_out.reg_write;
    assign IorD       = ctrl_out.iord;
    assign MemWrite   = ctrl_out.mem_write;
    assign IRWrite    = ctrl_out.ir_write;
    assign RegDst     = ctrl_out.reg_dst;
    assign MemtoReg   = ctrl_out.mem_to_reg;
    assign ALUSrcA    = ctrl_out.alu_src_a;
    assign ALUSrcB    = ctrl_out.alu_src_b;
    assign ALUControl = ctrl_out.alu_en ? alu_ctl : 3'b000;
    assign instr_done = ctrl_out.done;
    assign state_o    = state_q;

    assign count_d     = count_q + {{(CountWidth-1){1'b0}}, instr_done};
    assign instr_count = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            load_q  <= load_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected outputs are
// queued by the stimulus and compared by a negedge monitor.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op, Funct;
    logic       Zero;
    logic       PCWrite, RegWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, ALUSrcA, instr_done;
    logic [1:0] PCSrc, ALUSrcB;
    logic [2:0] ALUControl;
    logic [3:0] state_o;
    logic [3:0] instr_count;

    multicycle_control #(.CountWidth(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .IorD(IorD),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .state_o(state_o), .instr_done(instr_done), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // {PCWrite, PCSrc, RegWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUControl, instr_done}
    localparam logic [15:0] V_RESET  = 16'b0_00_0_0_0_0_0_0_0_00_000_0;
    localparam logic [15:0] V_FETCH  = 16'b1_00_0_0_0_1_0_0_0_01_010_0;
    localparam logic [15:0] V_DECODE = 16'b0_00_0_0_0_0_0_0_0_11_010_0;
    localparam logic [15:0] V_DECNOP = 16'b0_00_0_0_0_0_0_0_0_11_010_1;
    localparam logic [15:0] V_MEMADR = 16'b0_00_0_0_0_0_0_0_1_10_010_0;
    localparam logic [15:0] V_MEMRD  = 16'b0_00_0_1_0_0_0_0_0_00_000_0;
    localparam logic [15:0] V_MEMWB  = 16'b0_00_1_0_0_0_0_1_0_00_000_1;
    localparam logic [15:0] V_MEMWR  = 16'b0_00_0_1_1_0_0_0_0_00_000_1;
    localparam logic [15:0] V_ALUWB  = 16'b0_00_1_0_0_0_1_0_0_00_000_1;
    localparam logic [15:0] V_ADDIEX = 16'b0_00_0_0_0_0_0_0_1_10_010_0;
    localparam logic [15:0] V_ADDIWB = 16'b0_00_1_0_0_0_0_0_0_00_000_1;
    localparam logic [15:0] V_JUMP   = 16'b1_10_0_0_0_0_0_0_0_00_000_1;

    function automatic logic [15:0] v_exec(input logic [2:0] c, input logic done);
        return {12'b0_00_0_0_0_0_0_0_1_00, c, done};
    endfunction

    function automatic logic [15:0] v_branch(input logic z);
        return {z, 15'b01_0_0_0_0_0_0_1_00_110_1};
    endfunction

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [15:0] v;
        logic [3:0] cnt;
    } rec_t;

    rec_t       sb[$];
    rec_t       mon_r;
    logic [3:0] exp_cnt;
    int         checks = 0;
    int         failures = 0;
    logic [15:0] act;

    assign act = {PCWrite, PCSrc, RegWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
                  ALUSrcA, ALUSrcB, ALUControl, instr_done};

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_r = sb.pop_front();
            checks++;
            if (state_o !== mon_r.st || act !== mon_r.v || instr_count !== mon_r.cnt) begin
                failures++;
                $display("FAIL %s: got state=%0d out=%b count=%0d, expected state=%0d out=%b count=%0d",
                         mon_r.tag, state_o, act, instr_count, mon_r.st, mon_r.v, mon_r.cnt);
            end
        end
    end

    task automatic expect_cyc(input string tag, input logic [3:0] st, input logic [15:0] v);
        rec_t r;
        r.tag = tag; r.st = st; r.v = v; r.cnt = exp_cnt;
        sb.push_back(r);
        if (v[0]) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] f, input logic z);
        Op = op; Funct = f; Zero = z;
    endtask

    task automatic r_type(input string tag, input logic [5:0] f, input logic [2:0] c);
        set_in(6'b000000, f, 1'b0);
        expect_cyc({tag, "_fetch"}, 4'd0, V_FETCH);
        expect_cyc({tag, "_decode"}, 4'd1, V_DECODE);
        expect_cyc({tag, "_exec"}, 4'd6, v_exec(c, 1'b0));
        expect_cyc({tag, "_aluwb"}, 4'd7, V_ALUWB);
        go(4);
    endtask

    task automatic jump(input string tag);
        set_in(6'b000010, 6'b0, 1'b0);
        expect_cyc({tag, "_fetch"}, 4'd0, V_FETCH);
        expect_cyc({tag, "_decode"}, 4'd1, V_DECODE);
        expect_cyc({tag, "_jump"}, 4'd11, V_JUMP);
        go(3);
    endtask

    task automatic hold_reset(input string tag);
        reset = 1'b1;
        exp_cnt = 4'd0;
        repeat (3) expect_cyc(tag, 4'd0, V_RESET);
        go(3);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_in(6'b0, 6'b0, 1'b0);
        exp_cnt = 4'd0;
        repeat (3) expect_cyc("reset", 4'd0, V_RESET);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // lw: 5 cycles, retires with count 0 -> 1
        set_in(6'b100011, 6'b0, 1'b0);
        expect_cyc("lw_fetch", 4'd0, V_FETCH);
        expect_cyc("lw_decode", 4'd1, V_DECODE);
        expect_cyc("lw_memadr", 4'd2, V_MEMADR);
        expect_cyc("lw_memrd", 4'd3, V_MEMRD);
        expect_cyc("lw_memwb", 4'd4, V_MEMWB);
        go(5);

        r_type("slt", 6'b101010, 3'b111);
        r_type("add", 6'b100000, 3'b010);
        r_type("sub", 6'b100010, 3'b110);
        r_type("and", 6'b100100, 3'b000);
        r_type("or",  6'b100101, 3'b001);

        set_in(6'b000100, 6'b0, 1'b1);
        expect_cyc("beq1_fetch", 4'd0, V_FETCH);
        expect_cyc("beq1_decode", 4'd1, V_DECODE);
        expect_cyc("beq1_branch", 4'd8, v_branch(1'b1));
        go(3);
        set_in(6'b000100, 6'b0, 1'b0);
        expect_cyc("beq0_fetch", 4'd0, V_FETCH);
        expect_cyc("beq0_decode", 4'd1, V_DECODE);
        expect_cyc("beq0_branch", 4'd8, v_branch(1'b0));
        go(3);

        set_in(6'b001000, 6'b0, 1'b0);
        expect_cyc("addi_fetch", 4'd0, V_FETCH);
        expect_cyc("addi_decode", 4'd1, V_DECODE);
        expect_cyc("addi_ex", 4'd9, V_ADDIEX);
        expect_cyc("addi_wb", 4'd10, V_ADDIWB);
        go(4);

        jump("j");

        set_in(6'b101011, 6'b0, 1'b0);
        expect_cyc("sw_fetch", 4'd0, V_FETCH);
        expect_cyc("sw_decode", 4'd1, V_DECODE);
        expect_cyc("sw_memadr", 4'd2, V_MEMADR);
        expect_cyc("sw_memwr", 4'd5, V_MEMWR);
        go(4);

        // sw interrupted by reset while in MEMADR
        set_in(6'b101011, 6'b0, 1'b0);
        expect_cyc("swr_fetch", 4'd0, V_FETCH);
        expect_cyc("swr_decode", 4'd1, V_DECODE);
        go(2);
        hold_reset("swr_reset");

        set_in(6'b111111, 6'b0, 1'b0);
        expect_cyc("badop_fetch", 4'd0, V_FETCH);
        expect_cyc("badop_decode", 4'd1, V_DECNOP);
        go(2);
        set_in(6'b000000, 6'b000000, 1'b0);
        expect_cyc("badfn_fetch", 4'd0, V_FETCH);
        expect_cyc("badfn_decode", 4'd1, V_DECODE);
        expect_cyc("badfn_exec", 4'd6, v_exec(3'b010, 1'b1));
        go(3);

        // counter runs 2 -> 18, wrapping through 15 -> 0 in a 4-bit counter
        for (int i = 0; i < 16; i++) jump("jwrap");
        expect_cyc("final_fetch", 4'd0, V_FETCH);
        go(1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d records left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the 32-bit multicycle MIPS data path.
- Sequences fetch, decode, execute, memory and writeback by driving every data path control input.
- Inputs are the decoded Op, Funct and Zero fed back from the data path.
- Also reports the current state, an instruction-retired pulse and a retired-instruction counter for bring-up and debug.

Parameters:
- CountWidth, 32, width of the retired-instruction counter instr_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Op  in  6  instruction opcode from the data path IR.
- Funct  in  6  R-type function field from the data path IR.
- Zero  in  1  ALU zero flag.
- PCWrite  out  1  PC register enable.
- PCSrc  out  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- RegWrite  out  1  register file write enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register enable.
- RegDst  out  1  destination register select: 0 = rt, 1 = rd.
- MemtoReg  out  1  writeback data select: 0 = ALUOut, 1 = memory data.
- ALUSrcA  out  1  ALU operand A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU operand B select: 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- ALUControl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- state_o  out  4  current state encoding.
- instr_done  out  1  one-cycle pulse in the last cycle of each retired instruction.
- instr_count  out  CountWidth  number of retired instructions.

Behaviour:
- Reset:
  - Reset is asynchronous and active-high. While reset = 1: state = FETCH, instr_count = 0.
  - All strobes (PCWrite, RegWrite, MemWrite, IRWrite, instr_done) are forced to 0 combinationally.
  - All select outputs are forced to 0.
  - The first rising edge after reset deasserts completes a FETCH cycle.
- State encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Output model:
  - All outputs are Moore, decoded from the state register.
  - Exceptions: ALUControl in EXECUTE depends on Funct; PCWrite in BRANCH is Zero.
  - Any output not listed for a state is 0.
- Per-state outputs:
  - FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, PCWrite=1. Next state DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target into ALUOut). Next state by Op:
    - lw/sw -> MEMADR; R -> EXECUTE; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
    - Any other Op -> FETCH with instr_done=1 (treated as NOP).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next state MEMRD if lw, MEMWR if sw.
  - MEMRD: IorD=1. Next state MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Next state FETCH.
  - MEMWR: IorD=1, MemWrite=1, instr_done=1. Next state FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
    - Supported Funct: next state ALUWB.
    - Unsupported Funct: ALUControl=010, next state FETCH, instr_done=1, no register write.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Next state FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, PCWrite=Zero, instr_done=1. Next state FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next state ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Next state FETCH.
  - JUMP: PCSrc=10, PCWrite=1, instr_done=1. Next state FETCH.
  - Unused encodings 12-15: all outputs 0, next state FETCH.
- Latency (cycles, FETCH through retire):
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; unsupported opcode 2.
- Counter:
  - instr_count increments by 1 on every clock edge where instr_done=1.
  - Wraps modulo 2^CountWidth.
- Reset mid-instruction: state returns to FETCH immediately, all strobes drop in the same cycle, and no partial writes are issued after assertion.
- Op and Funct are sampled only in DECODE and EXECUTE; they are don't-care in all other states.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state localparams;
  - opcode and funct constants;
  - ALUControl codes;
  - PCSrc and ALUSrcB encodings.
- One sub-module, alu_decoder: inputs Funct and a 2-bit ALUOp (00 add, 01 sub, 10 funct); output ALUControl.
- The FSM, output decode and counter stay in multicycle_control.

Test Plan:
- Reset held 3 cycles, then released -> all strobes 0 during reset; cycle 1 after release shows FETCH (IRWrite=1, PCWrite=1, ALUSrcB=01); instr_count=0.
- Op=100011 (lw) -> states 0,1,2,3,4; RegWrite=1 with MemtoReg=1 only in MEMWB; instr_done pulses once; instr_count=1.
- Op=000000, Funct=101010 -> EXECUTE drives ALUControl=111; ALUWB drives RegDst=1, RegWrite=1; 4 cycles total.
- Op=000100 twice: first with Zero=1 -> PCWrite=1, PCSrc=01 in BRANCH; second with Zero=0 -> PCWrite=0; each takes 3 cycles.
- Op=101011 (sw) with reset asserted during MEMADR -> MemWrite never asserts; state_o=0 immediately; resumes from FETCH after release.
- Op=111111, then Op=000000 with Funct=000000 -> each returns to FETCH without RegWrite or MemWrite; instr_count increments by 2.
